// File: rtl/spi_master_cfg.sv
// spi_master_cfg
// -----------------------------------------------------------------------------
// Single-clock SPI master with programmable sclk divider, all four CPOL/CPHA
// modes, 1..DATA_W bit LSB-first transfers and N_SS one-hot active-low slave
// selects. Controlled through a small register file on the sel/we/address bus.
//
// Bus handshake: a write happens on any posedge clk where sel & we are both 1.
// There is no wait state and no back-pressure. Reads need no strobe:
// data_out follows address combinationally.
//
// Register map:
//   0 START  (W)  start a transfer if idle; reads 0
//   1 READY  (R)  {0.., ready}
//   2 TX     (RW) transmit word
//   3 RX     (R)  last received word, right-aligned
//   4 CONFIG (RW) [7:0] div, [8] cpha, [9] cpol, [15:10] len, [19:16] ss_sel
//
// Ports:
//   clk, ctr_nrst      clock, asynchronous active-low reset
//   sclk, ss, mosi     SPI outputs (ss active-low)
//   miso               SPI input, already synchronous to clk
//   data_in, data_out  bus write / read data
//   address, we, sel   bus control
//   interrupt          one-cycle pulse when a transfer completes
// -----------------------------------------------------------------------------
module spi_master_cfg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int N_SS   = 4
) (
    input  logic              clk,
    input  logic              ctr_nrst,
    output logic              sclk,
    output logic [N_SS-1:0]   ss,
    output logic              mosi,
    input  logic              miso,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic [ADDR_W-1:0] address,
    input  logic              we,
    input  logic              sel,
    output logic              interrupt
);

    // Edge counter must hold 2*DATA_W.
    localparam int EW = $clog2(2 * DATA_W) + 1;

    localparam logic [ADDR_W-1:0] A_START = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_READY = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TX    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_RX    = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_CFG   = ADDR_W'(4);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t            state;
    logic              ready;
    logic [DATA_W-1:0] tx_reg, rx_reg;
    logic [7:0]        cfg_div;
    logic              cfg_cpha, cfg_cpol;
    logic [5:0]        cfg_len;
    logic [3:0]        cfg_ss_sel;

    // Shadow copies taken at START so bus writes during a transfer do not disturb it.
    logic [7:0]        sh_div;
    logic              sh_cpha;
    logic [EW-1:0]     sh_edges;
    logic [DATA_W-1:0] sh_tx, sh_rx;
    logic [7:0]        cnt;
    logic [EW-1:0]     edge_cnt;

    logic              wr_en, start_req, tick, leading, sample_edge;
    logic [EW-1:0]     len_ext, n_bits, edge_num, half, s_idx;
    logic [N_SS-1:0]   ss_pattern;

    always_comb begin
        wr_en     = sel & we;
        start_req = wr_en && (address == A_START) && (state == S_IDLE);
        tick      = (cnt == 8'd0);
        // Number of bits: min(len, DATA_W-1) + 1.
        len_ext   = EW'(cfg_len);
        n_bits    = ((len_ext > EW'(DATA_W - 1)) ? EW'(DATA_W - 1) : len_ext) + EW'(1);
        // edge_num is the 1-based number of the sclk edge about to be issued.
        // Odd edges lead (sclk leaves cpol); even edges trail.
        edge_num    = edge_cnt + EW'(1);
        leading     = edge_num[0];
        half        = edge_num >> 1;
        sample_edge = leading ^ sh_cpha;
        // Leading edge 2k+1 samples bit k; trailing edge 2k+2 samples bit k.
        s_idx       = leading ? half : half - EW'(1);
        ss_pattern  = '1;
        for (int i = 0; i < N_SS; i++) begin
            if (cfg_ss_sel == 4'(i)) ss_pattern[i] = 1'b0;
        end
    end

    always_comb begin
        data_out = '0;
        case (address)
            A_READY: data_out = DATA_W'(ready);
            A_TX:    data_out = tx_reg;
            A_RX:    data_out = rx_reg;
            A_CFG:   data_out = DATA_W'({cfg_ss_sel, cfg_len, cfg_cpol, cfg_cpha, cfg_div});
            default: data_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge ctr_nrst) begin
        if (!ctr_nrst) begin
            state      <= S_IDLE;
            sclk       <= 1'b0;
            ss         <= '1;
            mosi       <= 1'b0;
            interrupt  <= 1'b0;
            ready      <= 1'b1;
            tx_reg     <= '0;
            rx_reg     <= '0;
            cfg_div    <= 8'd3;
            cfg_cpha   <= 1'b0;
            cfg_cpol   <= 1'b0;
            cfg_len    <= 6'(DATA_W - 1);
            cfg_ss_sel <= 4'd0;
            sh_div     <= 8'd0;
            sh_cpha    <= 1'b0;
            sh_edges   <= '0;
            sh_tx      <= '0;
            sh_rx      <= '0;
            cnt        <= 8'd0;
            edge_cnt   <= '0;
        end else begin
            interrupt <= 1'b0;

            if (wr_en) begin
                if (address == A_TX) tx_reg <= data_in;
                if (address == A_CFG) begin
                    cfg_div    <= data_in[7:0];
                    cfg_cpha   <= data_in[8];
                    cfg_cpol   <= data_in[9];
                    cfg_len    <= data_in[15:10];
                    cfg_ss_sel <= data_in[19:16];
                end
            end

            case (state)
                S_IDLE: begin
                    sclk <= cfg_cpol;
                    ss   <= '1;
                    if (start_req) begin
                        sh_div   <= cfg_div;
                        sh_cpha  <= cfg_cpha;
                        sh_tx    <= tx_reg;
                        sh_rx    <= '0;
                        sh_edges <= n_bits << 1;
                        edge_cnt <= '0;
                        cnt      <= cfg_div;
                        ss       <= ss_pattern;
                        mosi     <= tx_reg[0];
                        ready    <= 1'b0;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP, S_SHIFT: begin
                    if (tick) begin
                        cnt      <= sh_div;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_num;
                        if (sample_edge) begin
                            sh_rx <= sh_rx | ({{(DATA_W-1){1'b0}}, miso} << s_idx);
                        end else if (leading || (edge_num != sh_edges)) begin
                            // Advance to bit 'half'; the final trailing edge has no next bit.
                            mosi <= |(sh_tx & ({{(DATA_W-1){1'b0}}, 1'b1} << half));
                        end
                        state <= (edge_num == sh_edges) ? S_HOLD : S_SHIFT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        ss        <= '1;
                        rx_reg    <= sh_rx;
                        ready     <= 1'b1;
                        interrupt <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Testbench for spi_master_cfg: directed scenarios plus randomized transfers.
// The driver updates a register-level model and pushes one expected-transfer
// record per accepted START; the monitor measures the SPI pins and checks
// them against the record when the interrupt pulse appears.
module tb_spi_master_cfg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int N_SS   = 4;

    logic              clk, ctr_nrst, sclk, mosi, miso, we, sel, interrupt;
    logic [N_SS-1:0]   ss;
    logic [DATA_W-1:0] data_in, data_out;
    logic [ADDR_W-1:0] address;

    spi_master_cfg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SS(N_SS)) dut (
        .clk(clk), .ctr_nrst(ctr_nrst), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .data_in(data_in), .data_out(data_out), .address(address),
        .we(we), .sel(sel), .interrupt(interrupt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

    // ---------------- miso source ----------------
    // 0: loopback of mosi, 1: tied 0, 2: tied 1, 3: inverted loopback
    int miso_mode = 0;
    always_comb begin
        case (miso_mode)
            0:       miso = mosi;
            1:       miso = 1'b0;
            2:       miso = 1'b1;
            default: miso = ~mosi;
        endcase
    end

    // ---------------- reference model ----------------
    typedef struct {
        int                n;
        int                h;
        bit                cpol;
        bit                cpha;
        int                ss_sel;
        logic [DATA_W-1:0] tx;
        logic [DATA_W-1:0] rx;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t cur;
    int    n_vec = 0;
    int    n_err = 0;

    int                m_div, m_len, m_ss_sel;
    bit                m_cpha, m_cpol, busy;
    logic [DATA_W-1:0] m_tx, m_rx;

    function automatic void model_reset();
        m_div = 3; m_cpha = 0; m_cpol = 0; m_len = DATA_W - 1; m_ss_sel = 0;
        m_tx = '0; m_rx = '0; busy = 0;
    endfunction

    function automatic logic [DATA_W-1:0] mask_of(input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return m[DATA_W-1:0];
    endfunction

    function automatic logic [N_SS-1:0] exp_ss(input int s);
        logic [N_SS-1:0] v;
        v = {N_SS{1'b1}};
        if (s < N_SS) v[s] = 1'b0;
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] cfg_word();
        return (DATA_W'(m_ss_sel) << 16) | (DATA_W'(m_len) << 10) |
               (DATA_W'(m_cpol) << 9) | (DATA_W'(m_cpha) << 8) | DATA_W'(m_div);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_write(input int a, input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        sel = 1'b1; we = 1'b1; address = ADDR_W'(a); data_in = d;
        @(posedge clk); #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        address = ADDR_W'(a);
        #1;
        d = data_out;
    endtask

    task automatic set_cfg(input int div, input bit cpha, input bit cpol, input int len, input int ss_sel);
        logic [DATA_W-1:0] w;
        m_div = div; m_cpha = cpha; m_cpol = cpol; m_len = len; m_ss_sel = ss_sel;
        w = cfg_word() | (DATA_W'($urandom) << 20);   // junk in unused bits
        bus_write(4, w);
    endtask

    task automatic issue_start();
        xfer_t x;
        @(posedge clk); #1;
        sel = 1'b1; we = 1'b1; address = '0; data_in = DATA_W'($urandom);
        if (!busy) begin
            x.n      = ((m_len > DATA_W - 1) ? DATA_W - 1 : m_len) + 1;
            x.h      = m_div + 1;
            x.cpol   = m_cpol;
            x.cpha   = m_cpha;
            x.ss_sel = m_ss_sel;
            x.tx     = m_tx & mask_of(x.n);
            case (miso_mode)
                0:       x.rx = m_tx & mask_of(x.n);
                1:       x.rx = '0;
                2:       x.rx = mask_of(x.n);
                default: x.rx = ~m_tx & mask_of(x.n);
            endcase
            exp_q.push_back(x);
            cur  = x;
            busy = 1;
        end
        @(posedge clk); #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic wait_done();
        logic [DATA_W-1:0] d;
        bit done;
        done = 0;
        for (int i = 0; i < 20000 && !done; i++) begin
            bus_read(1, d);
            if (d[0]) done = 1;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: ready stayed 0, required 1");
        end
        busy = 0;
        m_rx = cur.rx;
        bus_read(3, d);
        chk("rx", d, cur.rx);
    endtask

    task automatic do_xfer(input int div, input bit cpha, input bit cpol, input int len,
                           input int ss_sel, input logic [DATA_W-1:0] tx, input int mode);
        set_cfg(div, cpha, cpol, len, ss_sel);
        bus_write(2, tx);
        m_tx = tx;
        miso_mode = mode;
        issue_start();
        wait_done();
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int ss_low, rises, toggles, since_edge, gap_bad, pat_bad, mosi_idx;
        logic [DATA_W-1:0] mosi_word;
        logic prev_sclk, prev_int;
        xfer_t x;
        ss_low = 0; rises = 0; toggles = 0; since_edge = 0; gap_bad = 0; pat_bad = 0;
        mosi_idx = 0; mosi_word = '0; prev_sclk = 1'b0; prev_int = 1'b0;
        forever begin
            @(negedge clk);
            if (!ctr_nrst) begin
                exp_q.delete();
                ss_low = 0; rises = 0; toggles = 0; gap_bad = 0; pat_bad = 0;
                mosi_idx = 0; mosi_word = '0;
            end else begin
                if (interrupt && prev_int) begin
                    n_vec++; n_err++;
                    $display("FAIL int_width: interrupt high 2 cycles, required 1");
                end
                if (exp_q.size() > 0) begin
                    x = exp_q[0];
                    if (ss != {N_SS{1'b1}}) begin
                        ss_low++;
                        if (ss != exp_ss(x.ss_sel)) pat_bad++;
                    end
                    since_edge++;
                    if (sclk != prev_sclk) begin
                        toggles++;
                        if (sclk) rises++;
                        if (toggles > 1 && since_edge != x.h) gap_bad++;
                        since_edge = 0;
                        // sampling edge: leading for cpha=0, trailing for cpha=1
                        if ((sclk != x.cpol) ^ x.cpha) begin
                            if (mosi_idx < DATA_W) mosi_word[mosi_idx] = mosi;
                            mosi_idx++;
                        end
                    end
                end
                if (interrupt) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL spurious_int: interrupt with no transfer outstanding, required none");
                    end else begin
                        x = exp_q.pop_front();
                        chk("ss_low_cycles", 64'(ss_low),
                            64'((x.ss_sel < N_SS) ? (2 * x.n + 1) * x.h : 0));
                        chk("ss_pattern_bad", 64'(pat_bad), 64'd0);
                        chk("sclk_rises", 64'(rises), 64'(x.n));
                        chk("sclk_edges", 64'(toggles), 64'(2 * x.n));
                        chk("edge_gap_bad", 64'(gap_bad), 64'd0);
                        chk("mosi_count", 64'(mosi_idx), 64'(x.n));
                        chk("mosi_bits", 64'(mosi_word), 64'(x.tx));
                        chk("sclk_end", 64'(sclk), 64'(x.cpol));
                    end
                    ss_low = 0; rises = 0; toggles = 0; gap_bad = 0; pat_bad = 0;
                    mosi_idx = 0; mosi_word = '0;
                end
            end
            prev_sclk = sclk;
            prev_int  = interrupt;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [DATA_W-1:0] d, w;
        ctr_nrst = 1'b1; sel = 1'b0; we = 1'b0; address = '0; data_in = '0;
        model_reset();
        #2 ctr_nrst = 1'b0;
        #1;
        chk("rst_ss", 64'(ss), 64'({N_SS{1'b1}}));
        chk("rst_sclk", 64'(sclk), 64'd0);
        chk("rst_mosi", 64'(mosi), 64'd0);
        chk("rst_int", 64'(interrupt), 64'd0);
        repeat (3) @(posedge clk);
        #1 ctr_nrst = 1'b1;

        bus_read(1, d); chk("rst_ready", d, 1);
        bus_read(2, d); chk("rst_tx", d, m_tx);
        bus_read(3, d); chk("rst_rx", d, m_rx);
        bus_read(4, d); chk("rst_cfg", d, cfg_word());
        bus_read(0, d); chk("start_reads0", d, 0);

        // mode 0, div 0, 8 bits, loopback
        set_cfg(0, 0, 0, 7, 0);
        bus_read(4, d); chk("cfg_readback", d, cfg_word());
        bus_write(2, 32'hA5); m_tx = 32'hA5; miso_mode = 0;
        issue_start();
        bus_read(1, d); chk("ready_busy", d, 0);
        wait_done();

        // mode 3, div 2, 16 bits, miso tied 1; sclk idles high after cpol write
        set_cfg(2, 1, 1, 15, 0);
        @(posedge clk); #1;
        chk("sclk_idle_cpol1", 64'(sclk), 64'd1);
        bus_write(2, 32'h1234); m_tx = 32'h1234; miso_mode = 2;
        bus_read(2, d); chk("tx_readback", d, m_tx);
        issue_start();
        wait_done();

        // slave select index 2 and out-of-range index 5
        do_xfer(1, 0, 0, 7, 2, 32'h5A, 0);
        do_xfer(0, 1, 0, 3, 5, 32'h9, 3);

        // START and TX/CONFIG rewrite while busy
        set_cfg(1, 0, 0, 7, 0);
        bus_write(2, 32'h3C); m_tx = 32'h3C; miso_mode = 0;
        issue_start();
        repeat (6) @(posedge clk);
        bus_read(3, d); chk("rx_holds_busy", d, m_rx);
        set_cfg(0, 0, 0, 7, 0);
        bus_write(2, 32'hFF); m_tx = 32'hFF;
        issue_start();                          // ignored: transfer in flight
        wait_done();
        issue_start();
        wait_done();

        // unmapped address: writes ignored, reads 0
        bus_write(6, DATA_W'($urandom));
        bus_read(6, d); chk("unmapped_read", d, 0);

        // reset pulsed in the middle of SHIFT
        set_cfg(3, 1, 1, 31, 1);
        w = DATA_W'($urandom);
        bus_write(2, w); m_tx = w; miso_mode = 0;
        issue_start();
        repeat (60) @(posedge clk);
        #1 ctr_nrst = 1'b0;
        #1;
        chk("midrst_ss", 64'(ss), 64'({N_SS{1'b1}}));
        chk("midrst_sclk", 64'(sclk), 64'd0);
        chk("midrst_int", 64'(interrupt), 64'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 ctr_nrst = 1'b1;
        bus_read(1, d); chk("midrst_ready", d, 1);
        bus_read(3, d); chk("midrst_rx", d, 0);
        bus_read(4, d); chk("midrst_cfg", d, cfg_word());
        bus_read(2, d); chk("midrst_tx", d, 0);
        repeat (20) @(posedge clk);
        do_xfer(0, 0, 0, 7, 0, 32'h81, 0);

        // len clamped to DATA_W bits, full-word loopback
        do_xfer(1, $urandom_range(0, 1), $urandom_range(0, 1), 63, 0, DATA_W'($urandom), 0);

        // largest divider
        do_xfer(255, 0, 0, 0, 1, DATA_W'($urandom), 3);

        // randomized transfers
        for (int i = 0; i < 24; i++) begin
            do_xfer($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 63), $urandom_range(0, 7), DATA_W'($urandom),
                    $urandom_range(0, 3));
        end

        repeat (10) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL leftover: %0d transfers without interrupt, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
